// File: rtl/life_gen_seq.sv
// life_gen_seq: generation sequencer and Game of Life rule engine.
//
// The block copies the board into a snapshot, then issues N = X*Y consecutive
// nxt_bit strobes. The board register rotates right by one on each strobe and
// writes pipe_out into bit INS_POS. Strobe k carries the next-generation value
// of cell c_k = (INS_POS+1+k) mod N, which is the cell rotating into that slot.
//
// Ports:
//   clk       clock
//   reset     asynchronous, active-low reset
//   data      current board; cell (x,y) is at bit {y,x}
//   run       level; generations repeat while high, with GAP idle cycles between them
//   key_step  level; a 1->0 release requests one generation while idle
//   nxt_bit   registered strobe to the board: rotate, then insert
//   pipe_out  registered new cell value, valid while nxt_bit=1
//   busy      registered; high from SNAP through the last strobe
//   gen_count registered count of completed generations, wraps at 2^16
module life_gen_seq #(
   parameter int unsigned X       = 8,
   parameter int unsigned Y       = 8,
   parameter int unsigned LOG2X   = 3,
   parameter int unsigned LOG2Y   = 3,
   parameter int unsigned INS_POS = (Y - 1) * X - 3,
   parameter int unsigned GAP     = 50000000,
   parameter int unsigned GAP_W   = 26
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [X*Y-1:0]   data,
   input  logic             run,
   input  logic             key_step,
   output logic             nxt_bit,
   output logic             pipe_out,
   output logic             busy,
   output logic [15:0]      gen_count
);

   localparam int unsigned N  = X * Y;
   localparam int unsigned CW = LOG2X + LOG2Y;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SNAP = 2'd1,
      RUN  = 2'd2,
      GAPW = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [N-1:0]       snap_q, snap_d;
   logic [CW-1:0]      k_q, k_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               ks_dly_q, ks_dly_d;
   logic               nxt_bit_q, nxt_bit_d;
   logic               pipe_out_q, pipe_out_d;
   logic               busy_q, busy_d;
   logic [15:0]        gen_count_q, gen_count_d;

   logic               step_edge_c;
   logic               last_k_c;
   logic               gap_done_c;
   logic [CW-1:0]      cell_c;
   logic [LOG2X-1:0]   cell_x_c;
   logic [LOG2Y-1:0]   cell_y_c;
   logic [LOG2X-1:0]   nb_x_c;
   logic [LOG2Y-1:0]   nb_y_c;
   logic [3:0]         nsum_c;
   logic               rule_c;

   assign step_edge_c = ks_dly_q & ~key_step;
   assign last_k_c    = (k_q == CW'(N - 1));
   assign gap_done_c  = (gap_q == GAP_W'(GAP - 1));

   // Cell landing in the insert slot on this strobe; N is a power of two so the add wraps.
   assign cell_c   = CW'(INS_POS + 1) + k_q;
   assign cell_x_c = cell_c[LOG2X-1:0];
   assign cell_y_c = cell_c[CW-1:LOG2X];

   // Toroidal neighbour count from the snapshot; x/y wrap within their own widths.
   always_comb begin
      nsum_c = 4'd0;
      nb_x_c = '0;
      nb_y_c = '0;
      for (int dy = 0; dy < 3; dy++) begin
         for (int dx = 0; dx < 3; dx++) begin
            if (!(dx == 1 && dy == 1)) begin
               nb_x_c = cell_x_c + LOG2X'(dx) - LOG2X'(1);
               nb_y_c = cell_y_c + LOG2Y'(dy) - LOG2Y'(1);
               nsum_c = nsum_c + 4'(snap_q[{nb_y_c, nb_x_c}]);
            end
         end
      end
      rule_c = (nsum_c == 4'd3) | (snap_q[cell_c] & (nsum_c == 4'd2));
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (run || step_edge_c) state_d = SNAP;
         SNAP: state_d = RUN;
         RUN:  if (last_k_c) state_d = run ? GAPW : IDLE;
         GAPW: begin
            if (!run)            state_d = IDLE;
            else if (gap_done_c) state_d = SNAP;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      snap_d      = snap_q;
      k_d         = k_q;
      gap_d       = '0;
      ks_dly_d    = key_step;
      nxt_bit_d   = 1'b0;
      pipe_out_d  = 1'b0;
      gen_count_d = gen_count_q;
      case (state_q)
         SNAP: begin
            snap_d = data;
            k_d    = '0;
         end
         RUN: begin
            nxt_bit_d  = 1'b1;
            pipe_out_d = rule_c;
            k_d        = k_q + CW'(1);
            if (last_k_c) gen_count_d = gen_count_q + 16'd1;
         end
         GAPW: gap_d = gap_q + GAP_W'(1);
         default: ;
      endcase
      // busy also covers the last strobe, which is visible after RUN has been left.
      busy_d = (state_d == SNAP) || (state_d == RUN) || nxt_bit_d;
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snap_q      <= '0;
         k_q         <= '0;
         gap_q       <= '0;
         ks_dly_q    <= 1'b0;
         nxt_bit_q   <= 1'b0;
         pipe_out_q  <= 1'b0;
         busy_q      <= 1'b0;
         gen_count_q <= 16'd0;
      end else begin
         snap_q      <= snap_d;
         k_q         <= k_d;
         gap_q       <= gap_d;
         ks_dly_q    <= ks_dly_d;
         nxt_bit_q   <= nxt_bit_d;
         pipe_out_q  <= pipe_out_d;
         busy_q      <= busy_d;
         gen_count_q <= gen_count_d;
      end
   end

   assign nxt_bit   = nxt_bit_q;
   assign pipe_out  = pipe_out_q;
   assign busy      = busy_q;
   assign gen_count = gen_count_q;

endmodule

// File: tb/tb_life_gen_seq.sv
// Bench for life_gen_seq: the board register and a Life reference model live here.
module tb_life_gen_seq;

   localparam int NB  = 64;
   localparam int INS = 53;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [63:0]   board = 64'd0;
   logic          run = 1'b0;
   logic          key_step = 1'b0;
   logic          nxt_bit, pipe_out, busy;
   logic [15:0]   gen_count;

   logic          ld = 1'b0;
   logic [63:0]   ld_val = 64'd0;
   logic [63:0]   rot;
   int            strobes = 0;
   int            low_run = 0;
   logic          gap_rec = 1'b0;
   int            gaps[$];

   int            total = 0;
   int            bad = 0;
   int            exp_gen = 0;

   life_gen_seq #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .GAP(4)) dut (
      .clk(clk), .reset(reset), .data(board), .run(run), .key_step(key_step),
      .nxt_bit(nxt_bit), .pipe_out(pipe_out), .busy(busy), .gen_count(gen_count)
   );

   always #5 clk = ~clk;

   // Consumer board: rotate right by one and insert pipe_out on each strobe.
   always @(posedge clk) begin
      if (ld) begin
         board <= ld_val;
      end else if (nxt_bit) begin
         rot = {board[0], board[63:1]};
         rot[INS] = pipe_out;
         board <= rot;
      end
   end

   always @(posedge clk) if (nxt_bit) strobes <= strobes + 1;

   // Lengths of nxt_bit low stretches between bursts.
   always @(negedge clk) begin
      if (nxt_bit) begin
         if (gap_rec && low_run > 0) gaps.push_back(low_run);
         low_run = 0;
      end else begin
         low_run = low_run + 1;
      end
   end

   // Reference next generation on an 8x8 torus.
   function automatic logic [63:0] life_next(input logic [63:0] b);
      logic [63:0] r;
      int n;
      r = 64'd0;
      for (int y = 0; y < 8; y++) begin
         for (int x = 0; x < 8; x++) begin
            n = 0;
            for (int dy = -1; dy <= 1; dy++)
               for (int dx = -1; dx <= 1; dx++)
                  if (dx != 0 || dy != 0)
                     n += int'(b[((y + dy + 8) % 8) * 8 + ((x + dx + 8) % 8)]);
            r[y * 8 + x] = (n == 3) || (b[y * 8 + x] && n == 2);
         end
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, expv);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: timeout waiting for DUT", name);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [63:0] v);
      @(negedge clk);
      ld = 1'b1;
      ld_val = v;
      @(negedge clk);
      ld = 1'b0;
   endtask

   task automatic pulse_step();
      @(negedge clk);
      key_step = 1'b1;
      @(negedge clk);
      key_step = 1'b0;
   endtask

   // Wait until strobe count reaches target and the strobe has dropped.
   task automatic wait_strobes(input string name, input int target);
      int t;
      t = 0;
      while (!(strobes >= target && !nxt_bit) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) timeout(name);
   endtask

   task automatic one_gen(input string name);
      int s0;
      s0 = strobes;
      pulse_step();
      wait_strobes(name, s0 + NB);
      cycles(2);
      exp_gen++;
      check({name, "_strobes"}, 64'(strobes - s0), 64'(NB));
   endtask

   typedef struct {
      string       name;
      logic [63:0] init;
      int          steps;
      logic [63:0] expv;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [63:0] prev, blk;
      int s0, t;

      tbl[0] = '{"blinker",  (64'd1<<26)|(64'd1<<27)|(64'd1<<28), 1, (64'd1<<19)|(64'd1<<27)|(64'd1<<35)};
      tbl[1] = '{"wrap1",    (64'd1<<7)|(64'd1<<0)|(64'd1<<1),    1, (64'd1<<56)|(64'd1<<0)|(64'd1<<8)};
      tbl[2] = '{"wrap2",    (64'd1<<7)|(64'd1<<0)|(64'd1<<1),    2, (64'd1<<7)|(64'd1<<0)|(64'd1<<1)};
      tbl[3] = '{"block",    (64'd1<<9)|(64'd1<<10)|(64'd1<<17)|(64'd1<<18), 1, (64'd1<<9)|(64'd1<<10)|(64'd1<<17)|(64'd1<<18)};
      tbl[4] = '{"empty",    64'd0, 1, 64'd0};
      tbl[5] = '{"lonely",   64'd1<<63, 1, 64'd0};

      cycles(3);
      reset = 1'b1;
      cycles(2);
      check("rst_nxt_bit", 64'(nxt_bit), 64'd0);
      check("rst_pipe_out", 64'(pipe_out), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_gen_count", 64'(gen_count), 64'd0);

      // Table of known patterns.
      for (int i = 0; i < 6; i++) begin
         load(tbl[i].init);
         for (int s = 0; s < tbl[i].steps; s++) one_gen(tbl[i].name);
         check({tbl[i].name, "_board"}, board, tbl[i].expv);
         check({tbl[i].name, "_gen"}, 64'(gen_count), 64'(exp_gen));
         check({tbl[i].name, "_busy"}, 64'(busy), 64'd0);
      end

      // Random boards against the reference model.
      for (int i = 0; i < 8; i++) begin
         prev = {32'($urandom), 32'($urandom)};
         if (i >= 4) prev = prev & {32'($urandom), 32'($urandom)};
         load(prev);
         one_gen("rand");
         check("rand_board", board, life_next(prev));
         check("rand_gen", 64'(gen_count), 64'(exp_gen));
      end

      // Still life under run for three generations, with gap length measured.
      blk = (64'd1<<9)|(64'd1<<10)|(64'd1<<17)|(64'd1<<18);
      load(blk);
      s0 = strobes;
      gaps.delete();
      @(negedge clk);
      run = 1'b1;
      t = 0;
      while (!nxt_bit && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) timeout("run_start");
      @(negedge clk);
      gap_rec = 1'b1;
      t = 0;
      while (gen_count != 16'(exp_gen + 2) && t < 1000) begin @(negedge clk); t++; end
      if (t >= 1000) timeout("run_gen2");
      t = 0;
      while (nxt_bit && t < 100) begin @(negedge clk); t++; end
      while (!nxt_bit && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) timeout("run_gen3_start");
      run = 1'b0;
      wait_strobes("run_end", s0 + 3 * NB);
      gap_rec = 1'b0;
      cycles(30);
      exp_gen += 3;
      check("run_strobes", 64'(strobes - s0), 64'(3 * NB));
      check("run_gen", 64'(gen_count), 64'(exp_gen));
      check("run_board", board, blk);
      check("run_busy", 64'(busy), 64'd0);
      check("run_gap_count", 64'(gaps.size()), 64'd2);
      foreach (gaps[j]) check("run_gap_len", 64'(gaps[j]), 64'd5);

      // Step request during RUN is ignored.
      prev = {32'($urandom), 32'($urandom)};
      load(prev);
      s0 = strobes;
      pulse_step();
      t = 0;
      while (strobes - s0 < 5 && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) timeout("ign_start");
      pulse_step();
      wait_strobes("ign_end", s0 + NB);
      cycles(150);
      exp_gen++;
      check("ign_strobes", 64'(strobes - s0), 64'(NB));
      check("ign_gen", 64'(gen_count), 64'(exp_gen));
      check("ign_board", board, life_next(prev));

      // run dropped mid-generation finishes it and stops.
      prev = {32'($urandom), 32'($urandom)};
      load(prev);
      s0 = strobes;
      @(negedge clk);
      run = 1'b1;
      t = 0;
      while (strobes - s0 < 10 && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) timeout("drop_start");
      run = 1'b0;
      wait_strobes("drop_end", s0 + NB);
      cycles(150);
      exp_gen++;
      check("drop_strobes", 64'(strobes - s0), 64'(NB));
      check("drop_gen", 64'(gen_count), 64'(exp_gen));
      check("drop_busy", 64'(busy), 64'd0);
      check("drop_board", board, life_next(prev));

      // Reset in the middle of RUN.
      load({32'($urandom), 32'($urandom)});
      s0 = strobes;
      pulse_step();
      t = 0;
      while (strobes - s0 < 20 && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) timeout("mid_rst_start");
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_nxt_bit", 64'(nxt_bit), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_gen", 64'(gen_count), 64'd0);
      cycles(2);
      reset = 1'b1;
      exp_gen = 0;
      s0 = strobes;
      cycles(150);
      check("mid_rst_quiet", 64'(strobes - s0), 64'd0);

      // Normal operation after reset.
      prev = {32'($urandom), 32'($urandom)};
      load(prev);
      one_gen("post_rst");
      check("post_rst_board", board, life_next(prev));
      check("post_rst_gen", 64'(gen_count), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
